// File: rtl/spi_wait_arbiter_pkg.sv
// Shared constants for the SPI wait-channel arbiter: state encoding, ID width,
// default timeout and the read-data fill value.
package spi_wait_arbiter_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned ID_W     = $clog2(NREQ_MAX);
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CNT_W    = 24;

    localparam logic [CNT_W-1:0]  TMO_CYCLES_DFLT = 24'd3_500_000;
    localparam logic [DATA_W-1:0] RDATA_FILL      = 8'hFF;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PEND = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/spi_wait_arbiter_rr_pick.sv
// Combinational round-robin picker: the set request at the smallest
// distance (mod NREQ) from the pointer wins.
module spi_wait_arbiter_rr_pick
    import spi_wait_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_valid_c,
    output logic [ID_W-1:0] o_idx_c
);

    always_comb begin : p_pick
        int unsigned best_off;
        int unsigned off;
        int unsigned ptr;
        o_idx_c  = '0;
        best_off = NREQ;
        off      = 0;
        ptr      = 32'(i_ptr);
        for (int unsigned c = 0; c < NREQ; c++) begin
            if (i_req[c]) begin
                off = (c >= ptr) ? (c - ptr) : (c + NREQ - ptr);
                if (off < best_off) begin
                    best_off = off;
                    o_idx_c  = ID_W'(c);
                end
            end
        end
    end

    assign o_valid_c = |i_req;

endmodule

// File: rtl/spi_wait_arbiter.sv
// Round-robin arbiter sharing the AVR-serviced SPI wait channel among NREQ requesters.
// Optional PEND timeout is compiled in with `define WAITARB_TIMEOUT_EN.
module spi_wait_arbiter
    import spi_wait_arbiter_pkg::*;
#(
    parameter int unsigned      NREQ       = 4,
    parameter logic [CNT_W-1:0] TMO_CYCLES = TMO_CYCLES_DFLT
) (
    input  logic                   fclk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_rnw,
    input  logic [DATA_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic [DATA_W-1:0]      wait_addr,
    output logic [DATA_W-1:0]      wait_write,
    output logic                   wait_rnw,
    input  logic [DATA_W-1:0]      wait_read,
    input  logic                   wait_end,
    output logic                   pend,
    output logic [ID_W-1:0]        pend_id,
    output logic                   tmo
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [NREQ-1:0]   r_ack;
    logic              r_pend;
    logic [ID_W-1:0]   r_pend_id;
    logic              r_tmo;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_wait_addr;
    logic [DATA_W-1:0] r_wait_write;
    logic              r_wait_rnw;

    logic              w_valid_c;
    logic [ID_W-1:0]   w_win_c;
    logic [DATA_W-1:0] w_win_addr_c;
    logic [DATA_W-1:0] w_win_wdata_c;
    logic              w_win_rnw_c;
    logic [NREQ-1:0]   w_ack_c;
    logic [ID_W-1:0]   w_ptr_nxt_c;
    logic              w_tmo_hit_c;

    spi_wait_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_valid_c (w_valid_c),
        .o_idx_c   (w_win_c)
    );

    // Winner payload mux and one-hot ack for the granted requester
    always_comb begin
        w_win_addr_c  = '0;
        w_win_wdata_c = '0;
        w_win_rnw_c   = 1'b0;
        w_ack_c       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (ID_W'(k) == w_win_c) begin
                w_win_addr_c  = req_addr[DATA_W*k +: DATA_W];
                w_win_wdata_c = req_wdata[DATA_W*k +: DATA_W];
                w_win_rnw_c   = req_rnw[k];
            end
            w_ack_c[k] = (ID_W'(k) == r_pend_id);
        end
    end

    assign w_ptr_nxt_c = (r_pend_id == ID_W'(NREQ - 1)) ? '0 : r_pend_id + ID_W'(1);

`ifdef WAITARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // Counts PEND cycles; held at zero in IDLE so it starts fresh on PEND entry
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_PEND) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_tmo_hit_c = (r_state == ST_PEND) && (r_cnt == TMO_CYCLES - CNT_W'(1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO_CYCLES;
    assign w_tmo_hit_c  = 1'b0;
`endif

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_valid_c) w_state_nxt = ST_PEND;
            ST_PEND: if (wait_end || w_tmo_hit_c) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs; wait_* and pend_id only change on a new grant
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_ack        <= '0;
            r_pend       <= 1'b0;
            r_pend_id    <= '0;
            r_tmo        <= 1'b0;
            r_rdata      <= RDATA_FILL;
            r_wait_addr  <= '0;
            r_wait_write <= '0;
            r_wait_rnw   <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid_c) begin
                        r_pend       <= 1'b1;
                        r_pend_id    <= w_win_c;
                        r_wait_addr  <= w_win_addr_c;
                        r_wait_write <= w_win_wdata_c;
                        r_wait_rnw   <= w_win_rnw_c;
                    end
                end
                ST_PEND: begin
                    if (wait_end) begin
                        if (r_wait_rnw) r_rdata <= wait_read;
                        r_tmo  <= 1'b0;
                        r_pend <= 1'b0;
                        r_ack  <= w_ack_c;
                    end else if (w_tmo_hit_c) begin
                        if (r_wait_rnw) r_rdata <= RDATA_FILL;
                        r_tmo  <= 1'b1;
                        r_pend <= 1'b0;
                        r_ack  <= w_ack_c;
                    end
                end
                ST_DONE: r_ptr <= w_ptr_nxt_c;
                default: ;
            endcase
        end
    end

    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign wait_addr  = r_wait_addr;
    assign wait_write = r_wait_write;
    assign wait_rnw   = r_wait_rnw;
    assign pend       = r_pend;
    assign pend_id    = r_pend_id;
    assign tmo        = r_tmo;

endmodule

// File: tb/tb_spi_wait_arbiter.sv
// Scoreboard bench for spi_wait_arbiter: directed scenarios plus randomized
// request traffic checked against a round-robin reference model.
module tb_spi_wait_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rnw;
    } grant_t;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [7:0]      rdata;
        logic            tmo;
        logic            pend;
    } ack_t;

    logic              fclk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_rnw;
    logic [8*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   ack;
    logic [7:0]        rdata;
    logic [7:0]        wait_addr;
    logic [7:0]        wait_write;
    logic              wait_rnw;
    logic [7:0]        wait_read;
    logic              wait_end;
    logic              pend;
    logic [2:0]        pend_id;
    logic              tmo;

    int errors = 0;
    int checks = 0;

    grant_t gq[$];
    ack_t   aq[$];

    int         m_ptr   = 0;
    logic [7:0] m_rdata = 8'hFF;

    spi_wait_arbiter #(
        .NREQ       (NREQ),
        .TMO_CYCLES (24'd16)
    ) dut (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .req        (req),
        .req_rnw    (req_rnw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .rdata      (rdata),
        .wait_addr  (wait_addr),
        .wait_write (wait_write),
        .wait_rnw   (wait_rnw),
        .wait_read  (wait_read),
        .wait_end   (wait_end),
        .pend       (pend),
        .pend_id    (pend_id),
        .tmo        (tmo)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference: first raised request at or after m_ptr, wrapping modulo NREQ
    function automatic int exp_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic raise(input int i, input bit rnw, input logic [7:0] a, input logic [7:0] d);
        req[i]              = 1'b1;
        req_rnw[i]          = rnw;
        req_addr[8*i +: 8]  = a;
        req_wdata[8*i +: 8] = d;
    endtask

    // One complete transaction; called at a negedge while the DUT is IDLE or DONE
    task automatic run_txn(input logic [7:0] rd_val, input int svc_delay, input bit tmo_mode,
                           output int w);
        int     n;
        int     pcnt;
        grant_t g;
        ack_t   a;
        w = exp_winner();
        if (w < 0) begin
            checks++;
            errors++;
            $display("FAIL run_txn: no request raised");
            return;
        end
        g.id    = 3'(w);
        g.addr  = req_addr[8*w +: 8];
        g.wdata = req_wdata[8*w +: 8];
        g.rnw   = req_rnw[w];
        gq.push_back(g);
        n = 0;
        while (!pend && n < 16) begin
            @(negedge fclk);
            n++;
        end
        checks++;
        if (!pend) begin
            errors++;
            $display("FAIL grant_wait: pend=0 after %0d cycles, required 1", n);
            return;
        end
        if (!tmo_mode) begin
            repeat (svc_delay) @(negedge fclk);
            wait_read = rd_val;
            wait_end  = 1'b1;
            if (g.rnw) m_rdata = rd_val;
            a.ack = onehot(w); a.rdata = m_rdata; a.tmo = 1'b0; a.pend = 1'b0;
            aq.push_back(a);
            @(negedge fclk);
            wait_end = 1'b0;
            chk("ack_latency", 32'(ack != '0), 32'd1);
            n = 0;
            while (ack == '0 && n < 8) begin
                @(negedge fclk);
                n++;
            end
        end else begin
            if (g.rnw) m_rdata = 8'hFF;
            a.ack = onehot(w); a.rdata = m_rdata; a.tmo = 1'b1; a.pend = 1'b0;
            aq.push_back(a);
            pcnt = 0;
            n    = 0;
            while (ack == '0 && n < 64) begin
                if (pend) pcnt++;
                @(negedge fclk);
                n++;
            end
            chk("tmo_pend_cycles", 32'(pcnt), 32'(TMO));
        end
        m_ptr  = (w + 1) % NREQ;
        req[w] = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a grant starts or an ack pulses
    initial begin
        logic   prev_pend;
        grant_t ga;
        grant_t ge;
        ack_t   aa;
        ack_t   ae;
        prev_pend = 1'b0;
        forever begin
            @(negedge fclk);
            if (pend && !prev_pend) begin
                checks++;
                ga = '{pend_id, wait_addr, wait_write, wait_rnw};
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL grant: unexpected grant id=%0d", pend_id);
                end else begin
                    ge = gq.pop_front();
                    if (ga !== ge) begin
                        errors++;
                        $display("FAIL grant: got id=%0d addr=%h wdata=%h rnw=%b, required id=%0d addr=%h wdata=%h rnw=%b",
                                 ga.id, ga.addr, ga.wdata, ga.rnw, ge.id, ge.addr, ge.wdata, ge.rnw);
                    end
                end
            end
            if (ack != '0) begin
                checks++;
                aa = '{ack, rdata, tmo, pend};
                if (aq.size() == 0) begin
                    errors++;
                    $display("FAIL ack: unexpected ack=%b", ack);
                end else begin
                    ae = aq.pop_front();
                    if (aa !== ae) begin
                        errors++;
                        $display("FAIL ack: got ack=%b rdata=%h tmo=%b pend=%b, required ack=%b rdata=%h tmo=%b pend=%b",
                                 aa.ack, aa.rdata, aa.tmo, aa.pend, ae.ack, ae.rdata, ae.tmo, ae.pend);
                    end
                end
            end
            prev_pend = pend;
        end
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        req       = '0;
        req_rnw   = '0;
        req_addr  = '0;
        req_wdata = '0;
        wait_read = '0;
        wait_end  = 1'b0;
        repeat (3) @(negedge fclk);

        chk("rst_ack",        32'(ack),        32'h0);
        chk("rst_pend",       32'(pend),       32'h0);
        chk("rst_pend_id",    32'(pend_id),    32'h0);
        chk("rst_tmo",        32'(tmo),        32'h0);
        chk("rst_rdata",      32'(rdata),      32'hFF);
        chk("rst_wait_addr",  32'(wait_addr),  32'h0);
        chk("rst_wait_write", 32'(wait_write), 32'h0);
        chk("rst_wait_rnw",   32'(wait_rnw),   32'h0);
        rst_n = 1'b1;

        // Single read and single write
        raise(2, 1'b1, 8'h0C, 8'h11);
        run_txn(8'h5A, 0, 1'b0, w);
        chk("read_rdata", 32'(rdata), 32'h5A);
        raise(0, 1'b0, 8'h21, 8'hA7);
        run_txn(8'h3C, 2, 1'b0, w);

        // Spurious wait_end while idle
        repeat (2) @(negedge fclk);
        wait_read = 8'h33;
        wait_end  = 1'b1;
        @(negedge fclk);
        wait_end = 1'b0;
        repeat (3) @(negedge fclk);
        chk("spurious_pend",  32'(pend),  32'h0);
        chk("spurious_rdata", 32'(rdata), 32'(m_rdata));

        // Reset in the middle of a pending transaction
        raise(1, 1'b1, 8'h44, 8'h55);
        raise(3, 1'b0, 8'h66, 8'h77);
        w = exp_winner();
        gq.push_back('{3'(w), req_addr[8*w +: 8], req_wdata[8*w +: 8], req_rnw[w]});
        repeat (3) @(negedge fclk);
        chk("midpend_pend_before", 32'(pend), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_pend",    32'(pend),    32'h0);
        chk("midrst_ack",     32'(ack),     32'h0);
        chk("midrst_rdata",   32'(rdata),   32'hFF);
        chk("midrst_pend_id", 32'(pend_id), 32'h0);
        m_ptr   = 0;
        m_rdata = 8'hFF;
        @(negedge fclk);
        rst_n = 1'b1;
        run_txn(8'h9E, 1, 1'b0, w);
        run_txn(8'h12, 0, 1'b0, w);

        // Round-robin with every requester held active, from a fresh reset
        @(negedge fclk);
        rst_n = 1'b0;
        m_ptr = 0;
        m_rdata = 8'hFF;
        @(negedge fclk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) raise(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        for (int t = 0; t < 5; t++) begin
            run_txn(8'($urandom), int'($urandom_range(0, 3)), 1'b0, w);
            chk("rr_order", 32'(w), 32'(t % NREQ));
            raise(w, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && ($urandom_range(0, 1) == 1))
                    raise(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end
            if (req == '0)
                raise(int'($urandom_range(0, NREQ - 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            run_txn(8'($urandom), int'($urandom_range(0, 3)), 1'b0, w);
        end

`ifdef WAITARB_TIMEOUT_EN
        req = '0;
        raise(1, 1'b1, 8'hC3, 8'h00);
        run_txn(8'h00, 0, 1'b1, w);
        chk("tmo_set", 32'(tmo), 32'h1);
        raise(2, 1'b1, 8'h0D, 8'h00);
        run_txn(8'h6B, 1, 1'b0, w);
        chk("tmo_cleared", 32'(tmo), 32'h0);
`endif

        req = '0;
        repeat (5) @(negedge fclk);
        chk("grant_queue_empty", 32'(gq.size()), 32'h0);
        chk("ack_queue_empty",   32'(aq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_wait_arbiter.md
# spi_wait_arbiter

Shares the single AVR-serviced wait channel (wait_write / wait_read / wait_rnw / wait_end of the SPI slave) between several Z80-side requesters such as the gluclock and COM-port bridges. It grants one requester at a time in round-robin order and presents that requester's address, data and direction to the SPI slave. It flags the pending transaction and its source ID in AVR status bits, then returns read data and an acknowledge when the AVR ends the wait.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TMO_CYCLES, 24'd3_500_000: timeout in fclk cycles, used only with timeout compiled in.
- fclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester level request; held high until that requester's ack.
- req_rnw  in  NREQ  per-requester direction; 1 = read from AVR.
- req_addr  in  8*NREQ  per-requester address byte; requester i uses bits [8i+7:8i].
- req_wdata  in  8*NREQ  per-requester write data byte.
- ack  out  NREQ  one-cycle done pulse, one-hot.
- rdata  out  8  read data; valid while ack is high and held until the next ack.
- wait_addr  out  8  to the SPI slave gluclock_addr input.
- wait_write  out  8  to the SPI slave wait_write input.
- wait_rnw  out  1  to the SPI slave wait_rnw input.
- wait_read  in  8  from the SPI slave; data the AVR shifted in.
- wait_end  in  1  one-cycle pulse from the SPI slave on the wait-register CS rising edge.
- pend  out  1  transaction outstanding; goes into status_in.
- pend_id  out  3  granted requester index; goes into status_in.
- tmo  out  1  sticky timeout flag; cleared by any successful wait_end.

## Operation
- States: IDLE, PEND, DONE. Encoding is 2 bits: 00, 01, 10.
- IDLE:
  - If any req bit is high, select a winner by round-robin, starting at ptr and wrapping modulo NREQ.
  - Latch the winner's addr, wdata, rnw and index into wait_addr, wait_write, wait_rnw and pend_id.
  - Go to PEND.
- PEND:
  - pend=1.
  - On wait_end: if wait_rnw, capture wait_read into rdata; else rdata is unchanged. Go to DONE.
  - A req drop by the granted requester during PEND is ignored; the transaction completes.
- DONE:
  - ack[pend_id]=1 for exactly this cycle.
  - ptr ← (pend_id+1) mod NREQ.
  - Go to IDLE.
- wait_end in IDLE or DONE is ignored, with no side effects.
- wait_addr, wait_write, wait_rnw and pend_id hold their values outside PEND, so the SPI slave sees stable data before and after AVR CS edges.
- Requesters with req low are skipped. If req is all zero, the block stays in IDLE.
- Reset values:
  - State IDLE, ptr 0.
  - ack 0, pend 0, pend_id 0, tmo 0.
  - rdata 8'hFF, wait_addr 0, wait_write 0, wait_rnw 0.
- Reset mid-transaction aborts it. No ack is issued; the requester keeps req high and is re-arbitrated after reset.

## Timing
- All outputs are registered.
- Req seen in IDLE at edge k: pend=1 and wait_* valid from cycle k+1.
- wait_end sampled in PEND at edge m: ack and rdata valid at cycle m+1, pend=0 at m+1.
- Requester handshake: drop req on the edge where ack=1 is sampled. The arbiter re-samples req at the first IDLE cycle, ack+1.
- Back-to-back minimum: 3 cycles per transaction plus AVR service time.
- Fairness: with all requesters active, each is granted once per NREQ transactions.

## Configuration
- Macro WAITARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to PEND and counts each PEND cycle.
  - When the count reaches TMO_CYCLES-1 with no wait_end, set tmo=1, force rdata=8'hFF (for reads; writes leave rdata unchanged), and go to DONE.
  - wait_end in the same cycle as the timeout wins: normal completion, tmo cleared.
- Undefined: no counter exists, PEND waits indefinitely, and tmo is tied to 0.

## Structure
- Package spi_wait_arbiter_pkg holds:
  - the state encoding localparams;
  - the NREQ maximum (8) and ID width (3);
  - the default TMO_CYCLES;
  - the rdata reset/timeout fill value 8'hFF.
- Sub-module rr_pick: a combinational round-robin picker. Inputs are req[NREQ] and ptr; outputs are a valid flag and the winner index.

## Test plan
- Single read: req[2]=1, rnw=1, addr=8'h0C. pend=1 and pend_id=2 next cycle, wait_addr=8'h0C. Drive wait_read=8'h5A plus a wait_end pulse; ack=4'b0100 and rdata=8'h5A one cycle later.
- Single write: req[0], wdata=8'hA7. wait_write=8'hA7 and wait_rnw=0 while pending. After wait_end, ack[0] pulses and rdata keeps its previous value.
- Round-robin: all four req held high and re-asserted after each ack. Grant order is 0,1,2,3,0. After reset, ptr=0.
- Spurious wait_end: pulse in IDLE. No ack, state stays IDLE, rdata unchanged.
- Reset mid-PEND: assert rst_n=0 while pending. pend=0, ack=0 and rdata=8'hFF immediately (asynchronous); after release, the held req is re-granted.
- Timeout (WAITARB_TIMEOUT_EN, TMO_CYCLES=16): read pending with no wait_end. ack after 16 PEND cycles with rdata=8'hFF and tmo=1. A subsequent good transaction clears tmo.
